// File: rtl/sync_pkg.sv
// Shared types and default constants for the debounce block.
package sync_pkg;

   localparam int DEBOUNCE_CYCLES_DEFAULT = 16;
   localparam int GLITCH_WIDTH_DEFAULT    = 8;

   typedef enum logic [1:0] {
      STABLE_LOW  = 2'd0,
      RISING      = 2'd1,
      STABLE_HIGH = 2'd2,
      FALLING     = 2'd3
   } db_state_t;

endpackage

// File: rtl/tech_sync_bit.sv
// Two-flop level synchroniser, used only when the debouncer is asked to
// synchronise its own input. Runs on every clk edge, independent of enable.
module tech_sync_bit (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two-stage shift toward the clk domain.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/sync_debounce.sv
// Level debouncer with registered level/edge outputs and a saturating
// count of aborted transitions.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   STABLE_LOW  | accepted level 0, waiting for a 1 sample
//   RISING      | counting consecutive 1 samples toward acceptance
//   STABLE_HIGH | accepted level 1, waiting for a 0 sample
//   FALLING     | counting consecutive 0 samples toward acceptance
module sync_debounce
   import sync_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int GLITCH_WIDTH    = GLITCH_WIDTH_DEFAULT,
   parameter bit SYNC_INPUT      = 1'b0
) (
   input  logic                    clk,
   input  logic                    clk__enable,
   input  logic                    reset_n,
   input  logic                    sync_in,
   input  logic                    glitch_clear,
   output logic                    level,
   output logic                    rise,
   output logic                    fall,
   output logic [GLITCH_WIDTH-1:0] glitch_count
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0]           CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [GLITCH_WIDTH-1:0] GLITCH_MAX = '1;

   db_state_t                state, state_nx;
   logic [CW-1:0]            cnt, cnt_nx;
   logic                     level_nx, rise_nx, fall_nx, glitch_hit;
   logic [GLITCH_WIDTH-1:0]  glitch_nx;
   logic                     sample;

   generate
      if (SYNC_INPUT) begin : g_sync
         tech_sync_bit u_sync (
            .clk     (clk),
            .reset_n (reset_n),
            .d       (sync_in),
            .q       (sample)
         );
      end else begin : g_nosync
         assign sample = sync_in;
      end
   endgenerate

   // Next-state, counter and output decode; pulses default low each enabled cycle.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      level_nx   = level;
      rise_nx    = 1'b0;
      fall_nx    = 1'b0;
      glitch_hit = 1'b0;
      case (state)
         STABLE_LOW: begin
            if (sample) begin
               state_nx = RISING;
               cnt_nx   = CW'(1);
            end
         end
         RISING: begin
            if (!sample) begin
               state_nx   = STABLE_LOW;
               cnt_nx     = '0;
               glitch_hit = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nx = STABLE_HIGH;
               cnt_nx   = '0;
               level_nx = 1'b1;
               rise_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         STABLE_HIGH: begin
            if (!sample) begin
               state_nx = FALLING;
               cnt_nx   = CW'(1);
            end
         end
         FALLING: begin
            if (sample) begin
               state_nx   = STABLE_HIGH;
               cnt_nx     = '0;
               glitch_hit = 1'b1;
            end else if (cnt == CNT_LAST) begin
               state_nx = STABLE_LOW;
               cnt_nx   = '0;
               level_nx = 1'b0;
               fall_nx  = 1'b1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: begin
            state_nx = STABLE_LOW;
            cnt_nx   = '0;
            level_nx = 1'b0;
         end
      endcase

      // Clear wins over a coincident abort; the count sticks at all-ones.
      if (glitch_clear)
         glitch_nx = '0;
      else if (glitch_hit && (glitch_count != GLITCH_MAX))
         glitch_nx = glitch_count + 1'b1;
      else
         glitch_nx = glitch_count;
   end

   // Enable-gated state and output registers; outputs hold while disabled.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state        <= STABLE_LOW;
         cnt          <= '0;
         level        <= 1'b0;
         rise         <= 1'b0;
         fall         <= 1'b0;
         glitch_count <= '0;
      end else if (clk__enable) begin
         state        <= state_nx;
         cnt          <= cnt_nx;
         level        <= level_nx;
         rise         <= rise_nx;
         fall         <= fall_nx;
         glitch_count <= glitch_nx;
      end
   end

endmodule

// File: tb/tb_sync_debounce.sv
// Directed bench for sync_debounce with DEBOUNCE_CYCLES=4, GLITCH_WIDTH=8.
module tb_sync_debounce;

   logic       clk = 1'b0;
   logic       clk__enable;
   logic       reset_n;
   logic       sync_in;
   logic       glitch_clear;
   logic       level;
   logic       rise;
   logic       fall;
   logic [7:0] glitch_count;

   int checks = 0;
   int errors = 0;

   sync_debounce #(
      .DEBOUNCE_CYCLES (4),
      .GLITCH_WIDTH    (8),
      .SYNC_INPUT      (1'b0)
   ) dut (
      .clk          (clk),
      .clk__enable  (clk__enable),
      .reset_n      (reset_n),
      .sync_in      (sync_in),
      .glitch_clear (glitch_clear),
      .level        (level),
      .rise         (rise),
      .fall         (fall),
      .glitch_count (glitch_count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clk edge, then settle; rise and fall must never coexist.
   task automatic tick();
      @(posedge clk);
      #1;
      check_eq("rise_fall_excl", {31'd0, rise & fall}, 32'd0);
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   // Three high samples then a low one: aborted rise on the completing sample.
   task automatic glitch_pulse();
      sync_in = 1'b1;
      ticks(3);
      sync_in = 1'b0;
      tick();
   endtask

   initial begin
      reset_n      = 1'b0;
      clk__enable  = 1'b1;
      sync_in      = 1'b0;
      glitch_clear = 1'b0;
      #2;
      check_eq("rst_level", {31'd0, level}, 32'd0);
      check_eq("rst_rise", {31'd0, rise}, 32'd0);
      check_eq("rst_fall", {31'd0, fall}, 32'd0);
      check_eq("rst_glitch", {24'd0, glitch_count}, 32'd0);
      tick();
      reset_n = 1'b1;

      // Clean rise: four agreeing samples.
      sync_in = 1'b1;
      ticks(3);
      check_eq("rise_pre_level", {31'd0, level}, 32'd0);
      check_eq("rise_pre_pulse", {31'd0, rise}, 32'd0);
      tick();
      check_eq("rise_level", {31'd0, level}, 32'd1);
      check_eq("rise_pulse", {31'd0, rise}, 32'd1);
      tick();
      check_eq("rise_pulse_end", {31'd0, rise}, 32'd0);
      check_eq("rise_level_hold", {31'd0, level}, 32'd1);

      // Clean fall from stable high.
      sync_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_eq("fall_pre_rise", {31'd0, rise}, 32'd0);
         check_eq("fall_pre_fall", {31'd0, fall}, 32'd0);
      end
      tick();
      check_eq("fall_pulse", {31'd0, fall}, 32'd1);
      check_eq("fall_level", {31'd0, level}, 32'd0);
      check_eq("fall_no_rise", {31'd0, rise}, 32'd0);
      tick();
      check_eq("fall_pulse_end", {31'd0, fall}, 32'd0);
      check_eq("fall_glitch_none", {24'd0, glitch_count}, 32'd0);

      // Rising glitch aborted on the would-be accepting sample.
      glitch_pulse();
      check_eq("rglitch_level", {31'd0, level}, 32'd0);
      check_eq("rglitch_rise", {31'd0, rise}, 32'd0);
      check_eq("rglitch_count", {24'd0, glitch_count}, 32'd1);

      // Falling glitch: go high, dip low for two samples, return high.
      sync_in = 1'b1;
      ticks(4);
      check_eq("fglitch_setup", {31'd0, level}, 32'd1);
      sync_in = 1'b0;
      ticks(2);
      sync_in = 1'b1;
      tick();
      check_eq("fglitch_level", {31'd0, level}, 32'd1);
      check_eq("fglitch_fall", {31'd0, fall}, 32'd0);
      check_eq("fglitch_count", {24'd0, glitch_count}, 32'd2);
      sync_in = 1'b0;
      ticks(4);
      check_eq("fglitch_back_low", {31'd0, level}, 32'd0);

      // Saturation: 253 more glitches reach 255, then 47 more must not wrap.
      for (int i = 0; i < 253; i++) glitch_pulse();
      check_eq("sat_reach", {24'd0, glitch_count}, 32'd255);
      for (int i = 0; i < 47; i++) glitch_pulse();
      check_eq("sat_hold", {24'd0, glitch_count}, 32'd255);
      check_eq("sat_level", {31'd0, level}, 32'd0);

      // Clear coincident with an abort: clear wins.
      sync_in = 1'b1;
      ticks(3);
      sync_in      = 1'b0;
      glitch_clear = 1'b1;
      tick();
      glitch_clear = 1'b0;
      check_eq("clear_prio", {24'd0, glitch_count}, 32'd0);

      // Enable toggling 1,0,1,0,...: acceptance on the 7th clk edge.
      sync_in = 1'b1;
      for (int i = 1; i <= 7; i++) begin
         clk__enable = (i % 2 == 1);
         tick();
         if (i == 6) begin
            check_eq("en_pre_level", {31'd0, level}, 32'd0);
            check_eq("en_pre_rise", {31'd0, rise}, 32'd0);
         end
      end
      check_eq("en_level", {31'd0, level}, 32'd1);
      check_eq("en_rise", {31'd0, rise}, 32'd1);
      clk__enable = 1'b0;
      tick();
      check_eq("en_rise_held", {31'd0, rise}, 32'd1);
      clk__enable = 1'b1;
      tick();
      check_eq("en_rise_end", {31'd0, rise}, 32'd0);
      sync_in = 1'b0;
      ticks(4);
      check_eq("en_back_low", {31'd0, level}, 32'd0);

      // Reset mid-rise with counter=2 after leaving a glitch on the count.
      sync_in = 1'b1;
      tick();
      sync_in = 1'b0;
      tick();
      check_eq("rst_pre_glitch", {24'd0, glitch_count}, 32'd1);
      sync_in = 1'b1;
      ticks(2);
      reset_n = 1'b0;
      #1;
      check_eq("mid_rst_level", {31'd0, level}, 32'd0);
      check_eq("mid_rst_rise", {31'd0, rise}, 32'd0);
      check_eq("mid_rst_fall", {31'd0, fall}, 32'd0);
      check_eq("mid_rst_glitch", {24'd0, glitch_count}, 32'd0);
      #1;
      reset_n = 1'b1;
      ticks(3);
      check_eq("post_rst_pre_level", {31'd0, level}, 32'd0);
      tick();
      check_eq("post_rst_level", {31'd0, level}, 32'd1);
      check_eq("post_rst_rise", {31'd0, rise}, 32'd1);
      check_eq("post_rst_glitch", {24'd0, glitch_count}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
